fft_frame_streamer: RTL and testbench

//  Producer side of the FFT-bin stream (valid/tdata/tuser) consumed by the peak/amplitude search.

---
 rtl/fft_frame_streamer.sv | 156 +++++++++++++++
 tb/tb_fft_frame_streamer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_streamer.sv
// Ping-pong frame buffer that replays each captured FFT frame as one contiguous bin burst.
// Optional build macro FFT_HALF_SPECTRUM_EN: stream only bins 0..N/2-1 of each stored frame.
module fft_frame_streamer #(
  parameter int DATA_W     = 64,
  parameter int IDX_W      = 16,
  parameter int N_LOG2     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_tdata,
  output logic [IDX_W-1:0]  out_tuser,
  output logic              frame_done,
  output logic              overrun,
  output logic [15:0]       drop_cnt,
  output logic              busy,
  output logic [1:0]        dbg_state
);
  localparam int N = 1 << N_LOG2;
`ifdef FFT_HALF_SPECTRUM_EN
  localparam int LAST = N / 2 - 1;
`else
  localparam int LAST = N - 1;
`endif
  localparam logic [N_LOG2-1:0] LAST_IDX = N_LOG2'(LAST);
  localparam logic [N_LOG2-1:0] WR_LAST  = N_LOG2'(N - 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_GAP} state_t;
  typedef enum logic [1:0] {B_EMPTY, B_FULL, B_READING} bank_t;

  // Handshake: out_valid has no ready; every cycle with out_valid=1 is one consumed beat.
  logic [DATA_W-1:0] r_mem [0:2*N-1];
  state_t            r_state, w_next;
  bank_t             r_bank [2];
  logic              r_wbank, r_rbank, r_dropping;
  logic [N_LOG2-1:0] r_wcnt, r_raddr, r_tuser;
  logic [GW-1:0]     r_gcnt;
  logic              r_out_valid, r_frame_done, r_overrun;
  logic [DATA_W-1:0] r_tdata;
  logic [15:0]       r_drop_cnt;
  logic              w_pickup, w_read, w_last;
  logic              w_beat0, w_wfree, w_store, w_drop0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_pickup = 1'b0;
    w_read   = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_bank[r_rbank] == B_FULL) begin
          w_pickup = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_FETCH: begin
        w_read = 1'b1;
        w_next = S_STREAM;
      end
      S_STREAM: begin
        if (r_tuser == LAST_IDX) begin
          w_last = 1'b1;
          w_next = S_GAP;
        end else begin
          w_read = 1'b1;
        end
      end
      S_GAP: begin
        if (r_gcnt == GAP_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A bank released on this very edge may already take beat 0 of the next frame.
  assign w_beat0 = (r_wcnt == '0);
  assign w_wfree = (r_bank[r_wbank] == B_EMPTY) || (w_last && (r_rbank == r_wbank));
  assign w_store = in_valid && (w_beat0 ? w_wfree : !r_dropping);
  assign w_drop0 = in_valid && w_beat0 && !w_wfree;

  always_ff @(posedge clk) begin
    if (w_store) r_mem[{r_wbank, r_wcnt}] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank[0]    <= B_EMPTY;
      r_bank[1]    <= B_EMPTY;
      r_wbank      <= 1'b0;
      r_rbank      <= 1'b0;
      r_dropping   <= 1'b0;
      r_wcnt       <= '0;
      r_raddr      <= '0;
      r_tuser      <= '0;
      r_gcnt       <= '0;
      r_out_valid  <= 1'b0;
      r_tdata      <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_frame_done <= w_last;
      r_overrun    <= w_drop0;
      if (w_read) begin
        r_out_valid <= 1'b1;
        r_tdata     <= r_mem[{r_rbank, r_raddr}];
        r_tuser     <= r_raddr;
        r_raddr     <= r_raddr + 1'b1;
      end else begin
        r_out_valid <= 1'b0;
        r_tdata     <= '0;
        r_tuser     <= '0;
      end
      if (w_pickup) begin
        r_bank[r_rbank] <= B_READING;
        r_raddr         <= '0;
      end
      if (w_last) begin
        r_bank[r_rbank] <= B_EMPTY;
        r_rbank         <= ~r_rbank;
        r_gcnt          <= '0;
      end else if (r_state == S_GAP) begin
        r_gcnt <= r_gcnt + 1'b1;
      end
      // Dropped frames still consume N beats so the frame boundary stays aligned.
      if (in_valid) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (w_beat0) r_dropping <= !w_wfree;
      end
      if (w_drop0 && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_store && (r_wcnt == WR_LAST)) begin
        r_bank[r_wbank] <= B_FULL;
        r_wbank         <= ~r_wbank;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_tdata  = r_tdata;
  assign out_tuser  = IDX_W'(r_tuser);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;
  assign drop_cnt   = r_drop_cnt;
  assign busy       = (r_bank[0] == B_FULL) || (r_bank[1] == B_FULL) || (r_state != S_IDLE);
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_fft_frame_streamer.sv
// Randomized bench for fft_frame_streamer; a frame-level schedule model predicts beats, timing and drops.
module tb_fft_frame_streamer;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 16;
  localparam int N_LOG2 = 8;
  localparam int G      = 2;
  localparam int N      = 1 << N_LOG2;
`ifdef FFT_HALF_SPECTRUM_EN
  localparam int L = N / 2;
`else
  localparam int L = N;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_tdata;
  logic [IDX_W-1:0]  out_tuser;
  logic              frame_done, overrun, busy;
  logic [15:0]       drop_cnt;
  logic [1:0]        dbg_state;

  fft_frame_streamer #(.DATA_W(DATA_W), .IDX_W(IDX_W), .N_LOG2(N_LOG2), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_tdata(out_tdata), .out_tuser(out_tuser),
    .frame_done(frame_done), .overrun(overrun), .drop_cnt(drop_cnt),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and edge counter: cyc holds the index of the most recent rising edge.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: accepted frames, their stream start/end edges and drop edges.
  logic [IDX_W+DATA_W-1:0] exp_q[$];
  int start_q[$], done_q[$], ovr_q[$];
  int m_end[$];
  int m_prev_end = -100;
  int m_drops = 0;

  task automatic model_clear();
    exp_q.delete(); start_q.delete(); done_q.delete(); ovr_q.delete(); m_end.delete();
    m_prev_end = -100;
    m_drops = 0;
  endtask

  // Scoreboard
  logic mon_en = 1'b0;
  logic prev_valid = 1'b0;
  logic [IDX_W+DATA_W-1:0] mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_beat", {out_tuser, out_tdata}, '0);
        else begin
          mon_e = exp_q.pop_front();
          check("beat", {out_tuser, out_tdata}, mon_e);
        end
        if (!prev_valid) begin
          if (start_q.size() == 0) check("unexpected_burst", 1, 0);
          else check("burst_start_edge", cyc, start_q.pop_front());
        end
      end else begin
        check("tdata_idle_zero", out_tdata, '0);
      end
      if (frame_done) begin
        if (done_q.size() == 0) check("unexpected_frame_done", 1, 0);
        else check("frame_done_edge", cyc, done_q.pop_front());
      end
      if (overrun) begin
        if (ovr_q.size() == 0) check("unexpected_overrun", 1, 0);
        else check("overrun_edge", cyc, ovr_q.pop_front());
      end
      prev_valid = out_valid;
    end
  end

  // Drivers
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
    end
  endtask

  task automatic send_frame(input bit pat, input bit holes);
    logic [DATA_W-1:0] fd [N];
    int b, t, k, p;
    bit acc;
    acc = 1'b1;
    b = 0;
    for (int i = 0; i < N; i++)
      fd[i] = pat ? {32'(i), ~(32'(i))} : {$urandom, $urandom};
    for (int i = 0; i < N; i++) begin
      if (holes && ($urandom_range(0, 15) == 0)) idle(1);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = fd[i];
      if (i == 0) begin
        b = cyc + 1;
        k = m_end.size();
        // Target bank is the one holding the accepted frame two back; it must be released by b.
        acc = !((k >= 2) && (m_end[k-2] > b));
        if (!acc) begin
          m_drops++;
          ovr_q.push_back(b);
        end
      end
    end
    t = cyc + 1;
    if (acc) begin
      p = t + 1;
      if (m_prev_end + G + 1 > p) p = m_prev_end + G + 1;
      start_q.push_back(p + 1);
      done_q.push_back(p + 1 + L);
      m_end.push_back(p + 1 + L);
      m_prev_end = p + 1 + L;
      for (int j = 0; j < L; j++) exp_q.push_back({IDX_W'(j), fd[j]});
    end
  endtask

  task automatic wait_beat0_at(input int target);
    while (cyc + 2 < target) idle(1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4000 && (done_q.size() != 0 || exp_q.size() != 0); i++) @(negedge clk);
    repeat (G + 3) @(negedge clk);
    check({tag, "_done_pending"}, done_q.size(), 0);
    check({tag, "_beats_pending"}, exp_q.size(), 0);
    check({tag, "_overrun_pending"}, ovr_q.size(), 0);
    check({tag, "_drop_cnt"}, drop_cnt, m_drops);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_state_idle"}, dbg_state, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_tdata"}, out_tdata, 0);
    check({tag, "_tuser"}, out_tuser, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int k;
    bit seen;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Single patterned frame: bin 0 two edges after the last write
    send_frame(1'b1, 1'b0);
    idle(1);
    drain("single");

    // Randomly spaced frames with occasional input holes
    for (int f = 0; f < 6; f++) begin
      send_frame(1'b0, 1'b1);
      idle($urandom_range(0, 8));
    end
    idle(1);
    drain("random");

    // Four frames at full input rate: stored frames stream intact, late ones are dropped
    for (int f = 0; f < 4; f++) send_frame(1'b0, 1'b0);
    idle(1);
    drain("fullrate");

    // Beat 0 one edge before the target bank is released: dropped; a retry is accepted
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    k = m_end.size();
    wait_beat0_at(m_end[k-2] - 1);
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    idle(1);
    drain("early_drop");

    // Beat 0 on exactly the release edge: accepted
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);
    k = m_end.size();
    wait_beat0_at(m_end[k-2]);
    send_frame(1'b0, 1'b0);
    idle(1);
    drain("same_edge_free");
    check("same_edge_accepted", m_end.size(), k + 1);

    // Reset in the middle of a burst
    send_frame(1'b0, 1'b0);
    idle(1);
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (out_valid && out_tuser == 16'd100) seen = 1'b1;
    end
    check("reached_tuser_100", seen, 1);
    #1 rst = 1'b1;
    model_clear();
    @(negedge clk);
    check_all_zero("midreset");
    #1 rst = 1'b0;
    idle(300);
    send_frame(1'b1, 1'b0);
    idle(1);
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got %0d exp 0", cyc);
    $fatal(1, "timeout");
  end
endmodule
